// File: rtl/logic_gate_array_if.sv
// Mode-write channel of the logic gate array: a valid/ready write of a
// 3-bit function code into one gate channel.
interface logic_gate_array_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_chan;
    logic [2:0] cfg_mode;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_mode,
        output cfg_ready
    );
endinterface

// File: rtl/logic_gate_array.sv
// Array of configurable logic gates. Each channel applies its stored function
// to its input slice; results travel down a DELAY-deep shift line to emulate
// propagation delay. A toggle counter watches one selected output.
module logic_gate_array #(
    parameter int CHANNELS = 4,
    parameter int INPUTS   = 2,
    parameter int DELAY    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*INPUTS-1:0]   a,
    output logic [CHANNELS-1:0]          y,
    output logic                         y_valid,
    logic_gate_array_if.slave            cfg,
    input  logic [3:0]                   tgl_sel,
    input  logic                         tgl_clr,
    output logic [15:0]                  tgl_count
);

    localparam int CW = $clog2(DELAY + 1);

    typedef enum logic {
        CFG_IDLE,
        CFG_BUSY
    } cfg_state_t;

    cfg_state_t            cfg_state, cfg_state_nx;
    logic [CW-1:0]         busy_cnt, busy_cnt_nx;
    logic                  cfg_accept;

    logic [2:0]            mode [CHANNELS];
    logic [CHANNELS-1:0]   f_vec;
    logic [CHANNELS-1:0]   sh [DELAY];
    logic [CHANNELS-1:0]   y_next;
    logic [CW-1:0]         fill_cnt;
    logic                  sel_change;

    // Gate evaluation: each channel's function applied to its input slice
    always_comb begin
        f_vec = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin : g_eval
            logic [INPUTS-1:0] g;
            g = a[c*INPUTS +: INPUTS];
            case (mode[c])
                3'b000:  f_vec[c] = &g;
                3'b001:  f_vec[c] = ~&g;
                3'b010:  f_vec[c] = |g;
                3'b011:  f_vec[c] = ~|g;
                3'b100:  f_vec[c] = ^g;
                3'b101:  f_vec[c] = ~^g;
                3'b110:  f_vec[c] = g[0];
                default: f_vec[c] = ~g[0];
            endcase
        end
    end

    // Mode table: written on an accepted write to an existing channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) mode[c] <= '0;
        end else if (cfg_accept) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (4'(c) == cfg.cfg_chan) mode[c] <= cfg.cfg_mode;
            end
        end
    end

    // Propagation-delay shift line: stage 0 captures fresh gate results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < DELAY; s++) sh[s] <= '0;
        end else begin
            sh[0] <= f_vec;
            for (int unsigned s = 1; s < DELAY; s++) sh[s] <= sh[s-1];
        end
    end

    assign y = sh[DELAY-1];

    // y_next is what y will hold after the coming edge
    generate
        if (DELAY == 1) begin : g_next_direct
            assign y_next = f_vec;
        end else begin : g_next_line
            assign y_next = sh[DELAY-2];
        end
    endgenerate

    // Fill counter: y_valid once DELAY edges have passed since reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
        end else if (fill_cnt != CW'(DELAY)) begin
            fill_cnt <= fill_cnt + CW'(1);
        end
    end

    assign y_valid = (fill_cnt == CW'(DELAY));

    // Write-handshake state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_state <= CFG_IDLE;
            busy_cnt  <= '0;
        end else begin
            cfg_state <= cfg_state_nx;
            busy_cnt  <= busy_cnt_nx;
        end
    end

    // Write handshake: after an accept, hold ready low for DELAY cycles
    always_comb begin
        cfg_state_nx  = cfg_state;
        busy_cnt_nx   = busy_cnt;
        cfg.cfg_ready = (cfg_state == CFG_IDLE);
        cfg_accept    = cfg.cfg_valid && (cfg_state == CFG_IDLE);
        case (cfg_state)
            CFG_IDLE: begin
                if (cfg_accept) begin
                    cfg_state_nx = CFG_BUSY;
                    busy_cnt_nx  = CW'(DELAY);
                end
            end
            default: begin
                busy_cnt_nx = busy_cnt - CW'(1);
                if (busy_cnt == CW'(1)) cfg_state_nx = CFG_IDLE;
            end
        endcase
    end

    // Detect a transition of the monitored output across the coming edge
    always_comb begin
        sel_change = 1'b0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (4'(c) == tgl_sel) sel_change = y_next[c] ^ y[c];
        end
    end

    // Saturating toggle counter; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgl_count <= '0;
        end else if (tgl_clr) begin
            tgl_count <= '0;
        end else if (y_valid && sel_change && (tgl_count != '1)) begin
            tgl_count <= tgl_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_logic_gate_array.sv
// Bench for logic_gate_array: three instances with different parameter sets
// share one stimulus stream and are compared against a behavioural model.
module tb_logic_gate_array;

    logic        clk;
    logic        rst_n;
    logic [63:0] a_bus;
    logic        cfg_valid;
    logic [3:0]  cfg_chan;
    logic [2:0]  cfg_mode;
    logic [3:0]  tgl_sel;
    logic        tgl_clr;

    logic [3:0]  y_a, y_b;
    logic [15:0] y_c;
    logic        v_a, v_b, v_c;
    logic [15:0] t_a, t_b, t_c;

    logic [15:0] y_obs [3];
    logic        v_obs [3];
    logic        r_obs [3];
    logic [15:0] t_obs [3];

    int checks;
    int failures;

    // model state
    bit [2:0]  m_mode [3][16];
    bit [15:0] m_st   [3][16];
    int        m_busy [3];
    int        m_fill [3];
    int        m_tgl  [3];

    logic_gate_array_if if_a ();
    logic_gate_array_if if_b ();
    logic_gate_array_if if_c ();

    assign if_a.cfg_valid = cfg_valid;
    assign if_a.cfg_chan  = cfg_chan;
    assign if_a.cfg_mode  = cfg_mode;
    assign if_b.cfg_valid = cfg_valid;
    assign if_b.cfg_chan  = cfg_chan;
    assign if_b.cfg_mode  = cfg_mode;
    assign if_c.cfg_valid = cfg_valid;
    assign if_c.cfg_chan  = cfg_chan;
    assign if_c.cfg_mode  = cfg_mode;

    logic_gate_array #(.CHANNELS(4), .INPUTS(2), .DELAY(2)) u_a (
        .clk(clk), .rst_n(rst_n), .a(a_bus[7:0]), .y(y_a), .y_valid(v_a),
        .cfg(if_a), .tgl_sel(tgl_sel), .tgl_clr(tgl_clr), .tgl_count(t_a)
    );
    logic_gate_array #(.CHANNELS(4), .INPUTS(4), .DELAY(1)) u_b (
        .clk(clk), .rst_n(rst_n), .a(a_bus[15:0]), .y(y_b), .y_valid(v_b),
        .cfg(if_b), .tgl_sel(tgl_sel), .tgl_clr(tgl_clr), .tgl_count(t_b)
    );
    logic_gate_array #(.CHANNELS(16), .INPUTS(2), .DELAY(16)) u_c (
        .clk(clk), .rst_n(rst_n), .a(a_bus[31:0]), .y(y_c), .y_valid(v_c),
        .cfg(if_c), .tgl_sel(tgl_sel), .tgl_clr(tgl_clr), .tgl_count(t_c)
    );

    assign y_obs[0] = {12'b0, y_a};
    assign y_obs[1] = {12'b0, y_b};
    assign y_obs[2] = y_c;
    assign v_obs[0] = v_a;
    assign v_obs[1] = v_b;
    assign v_obs[2] = v_c;
    assign r_obs[0] = if_a.cfg_ready;
    assign r_obs[1] = if_b.cfg_ready;
    assign r_obs[2] = if_c.cfg_ready;
    assign t_obs[0] = t_a;
    assign t_obs[1] = t_b;
    assign t_obs[2] = t_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ch_of(int i);
        return (i == 2) ? 16 : 4;
    endfunction

    function automatic int in_of(int i);
        return (i == 1) ? 4 : 2;
    endfunction

    function automatic int dl_of(int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    // Gate outputs from the truth-table definitions, counting ones per slice
    function automatic bit [15:0] f_word(int i, logic [63:0] av);
        bit [15:0] w = '0;
        int n = in_of(i);
        for (int c = 0; c < ch_of(i); c++) begin
            logic [63:0] shv = av >> (c * n);
            int bits = int'(shv[3:0]) & ((1 << n) - 1);
            int ones = $countones(bits);
            case (m_mode[i][c])
                3'd0: w[c] = (ones == n);
                3'd1: w[c] = (ones != n);
                3'd2: w[c] = (ones != 0);
                3'd3: w[c] = (ones == 0);
                3'd4: w[c] = (ones % 2) == 1;
                3'd5: w[c] = (ones % 2) == 0;
                3'd6: w[c] = (bits % 2) == 1;
                default: w[c] = (bits % 2) == 0;
            endcase
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 16; c++) begin
                m_mode[i][c] = 3'd0;
                m_st[i][c]   = '0;
            end
            m_busy[i] = 0;
            m_fill[i] = 0;
            m_tgl[i]  = 0;
        end
    endtask

    // Advance the model by one edge using current inputs, then clock the DUTs
    task automatic step();
        for (int i = 0; i < 3; i++) begin
            int d = dl_of(i);
            bit [15:0] fnew = f_word(i, a_bus);
            bit [15:0] yold = m_st[i][0];
            bit [15:0] ynew;
            bit accept = cfg_valid && (m_busy[i] == 0);
            for (int s = 0; s < d - 1; s++) m_st[i][s] = m_st[i][s+1];
            m_st[i][d-1] = fnew;
            ynew = m_st[i][0];
            if (tgl_clr) m_tgl[i] = 0;
            else if (m_fill[i] >= d && int'(tgl_sel) < ch_of(i) &&
                     yold[tgl_sel] != ynew[tgl_sel] && m_tgl[i] < 65535)
                m_tgl[i]++;
            if (m_fill[i] < d) m_fill[i]++;
            if (accept) begin
                m_busy[i] = d;
                if (int'(cfg_chan) < ch_of(i)) m_mode[i][cfg_chan] = cfg_mode;
            end else if (m_busy[i] > 0) begin
                m_busy[i]--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_bus = '1;
        cfg_valid = 1'b0; cfg_chan = '0; cfg_mode = '0;
        tgl_sel = '0; tgl_clr = 1'b0;
        model_reset();
        #3;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (y_obs[i] !== 16'h0 || v_obs[i] !== 1'b0 || r_obs[i] !== 1'b1 || t_obs[i] !== 16'h0) begin
                failures++;
                $display("FAIL reset_state inst%0d: y=%h v=%b r=%b t=%h want 0 0 1 0",
                         i, y_obs[i], v_obs[i], r_obs[i], t_obs[i]);
            end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (v_a !== 1'b0) begin
            failures++; $display("FAIL valid_edge1 got %b want 0", v_a);
        end
        step();
        checks++;
        if (v_a !== 1'b1 || y_a !== 4'hF) begin
            failures++; $display("FAIL valid_edge2 got v=%b y=%h want v=1 y=f", v_a, y_a);
        end
        // AND truth table on all four channels
        for (int k = 0; k < 4; k++) begin
            logic [1:0] kk = 2'(k);
            a_bus = {32{kk}};
            step();
            step();
            checks++;
            if (y_a !== ((kk == 2'b11) ? 4'hF : 4'h0)) begin
                failures++; $display("FAIL and_table in=%b got %h", kk, y_a);
            end
        end
    endtask

    task automatic test_mode_write();
        a_bus = {56'hFF_FFFF_FFFF_FFFF, 8'hF7};
        step();
        step();
        checks++;
        if (y_a !== 4'b1101) begin
            failures++; $display("FAIL pre_write_y got %b want 1101", y_a);
        end
        cfg_valid = 1'b1; cfg_chan = 4'd1; cfg_mode = 3'b100;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (if_a.cfg_ready !== 1'b0) begin
            failures++; $display("FAIL ready_low1 got %b want 0", if_a.cfg_ready);
        end
        step();
        checks++;
        if (if_a.cfg_ready !== 1'b0 || y_a !== 4'b1101) begin
            failures++; $display("FAIL ready_low2 got r=%b y=%b want 0 1101", if_a.cfg_ready, y_a);
        end
        step();
        checks++;
        if (if_a.cfg_ready !== 1'b1 || y_a !== 4'hF) begin
            failures++; $display("FAIL xor_write got r=%b y=%b want 1 1111", if_a.cfg_ready, y_a);
        end
    endtask

    task automatic test_bad_chan();
        cfg_valid = 1'b1; cfg_chan = 4'd7; cfg_mode = 3'b111;
        step();
        checks++;
        if (if_a.cfg_ready !== 1'b0) begin
            failures++; $display("FAIL badchan_accept got %b want 0", if_a.cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        checks++;
        if (if_a.cfg_ready !== 1'b0) begin
            failures++; $display("FAIL badchan_low2 got %b want 0", if_a.cfg_ready);
        end
        step();
        checks++;
        if (if_a.cfg_ready !== 1'b1) begin
            failures++; $display("FAIL badchan_no_reaccept got %b want 1", if_a.cfg_ready);
        end
        step();
        step();
        checks++;
        if (y_a !== 4'hF) begin
            failures++; $display("FAIL badchan_modes got %b want 1111", y_a);
        end
    endtask

    task automatic test_toggle_sat();
        tgl_sel = 4'd0;
        tgl_clr = 1'b1;
        a_bus = {56'hFF_FFFF_FFFF_FFFF, 8'hF7};
        step();
        tgl_clr = 1'b0;
        for (int n = 0; n < 70000; n++) begin
            a_bus[0] = ~a_bus[0];
            step();
        end
        checks++;
        if (t_a !== 16'hFFFF) begin
            failures++; $display("FAIL tgl_saturate got %h want ffff", t_a);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (t_obs[i] !== 16'(m_tgl[i])) begin
                failures++; $display("FAIL tgl_model inst%0d got %h want %h", i, t_obs[i], 16'(m_tgl[i]));
            end
        end
        a_bus[0] = ~a_bus[0];
        tgl_clr = 1'b1;
        step();
        tgl_clr = 1'b0;
        checks++;
        if (t_a !== 16'h0) begin
            failures++; $display("FAIL tgl_clr_priority got %h want 0", t_a);
        end
    endtask

    task automatic test_reset_mid();
        cfg_valid = 1'b1; cfg_chan = 4'd2; cfg_mode = 3'b011;
        step();
        cfg_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (y_obs[i] !== 16'h0 || v_obs[i] !== 1'b0 || r_obs[i] !== 1'b1 || t_obs[i] !== 16'h0) begin
                failures++;
                $display("FAIL mid_reset inst%0d: y=%h v=%b r=%b t=%h want 0 0 1 0",
                         i, y_obs[i], v_obs[i], r_obs[i], t_obs[i]);
            end
        end
        model_reset();
        #1;
        rst_n = 1'b1;
        a_bus = '1;
        step();
        step();
        checks++;
        if (y_a !== 4'hF || v_a !== 1'b1) begin
            failures++; $display("FAIL post_reset_and got y=%b v=%b want 1111 1", y_a, v_a);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            a_bus     = {$urandom, $urandom};
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_chan  = 4'($urandom_range(0, 15));
            cfg_mode  = 3'($urandom_range(0, 7));
            tgl_sel   = 4'($urandom_range(0, 15));
            tgl_clr   = ($urandom_range(0, 15) == 0);
            step();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (y_obs[i] !== m_st[i][0]) begin
                    failures++; $display("FAIL rand_y inst%0d cyc%0d got %h want %h", i, n, y_obs[i], m_st[i][0]);
                end
                checks++;
                if (v_obs[i] !== (m_fill[i] >= dl_of(i))) begin
                    failures++; $display("FAIL rand_valid inst%0d cyc%0d got %b", i, n, v_obs[i]);
                end
                checks++;
                if (r_obs[i] !== (m_busy[i] == 0)) begin
                    failures++; $display("FAIL rand_ready inst%0d cyc%0d got %b want %b", i, n, r_obs[i], m_busy[i] == 0);
                end
                checks++;
                if (t_obs[i] !== 16'(m_tgl[i])) begin
                    failures++; $display("FAIL rand_tgl inst%0d cyc%0d got %h want %h", i, n, t_obs[i], 16'(m_tgl[i]));
                end
            end
        end
        cfg_valid = 1'b0;
        tgl_clr = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_mode_write();
        test_bad_chan();
        test_toggle_sat();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
